// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_e;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = 8 * WORD_BYTES;
    localparam int unsigned BYTE_IDX_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_program_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master: host byte source plus memory side; slave: the loader
    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/loader_word_assembler.sv
// Collects bytes MSB-first into a word; flags the byte that completes it.
module loader_word_assembler
    import mips_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_ready_c,
    output logic [WORD_W-1:0] word_c
);

    logic [WORD_W-9:0]     shift_q;
    logic [BYTE_IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (byte_valid) begin
            shift_q <= {shift_q[WORD_W-17:0], byte_data};
            idx_q   <= idx_q + BYTE_IDX_W'(1);
        end
    end

    // The completing byte bypasses the shift register so the word is usable this cycle
    assign word_ready_c = byte_valid && (idx_q == BYTE_IDX_W'(WORD_BYTES - 1));
    assign word_c       = {shift_q, byte_data};

endmodule

// File: rtl/imem_program_loader.sv
// Receives a framed program image as bytes and writes it word by word into
// instruction memory, holding the core until the load finishes.
module imem_program_loader
    import mips_loader_pkg::*;
#(
    parameter int unsigned             ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
    parameter int unsigned             MAX_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_program_loader_if.slave  bus,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);

    state_e            state_q, state_n;
    logic [15:0]       count_q;
    logic [7:0]        csum_q;
    logic              fire_c, sync_c, data_byte_c, last_word_c, word_ready_c;
    logic [15:0]       cnt_c;
    logic [WORD_W-1:0] word_c;

    assign fire_c      = bus.rx_valid && bus.rx_ready;
    assign sync_c      = (state_q == IDLE) && fire_c && (bus.rx_data == SYNC_BYTE);
    assign data_byte_c = (state_q == DATA) && fire_c;
    assign cnt_c       = {count_q[15:8], bus.rx_data};
    // words_loaded still holds this word's index when its last byte arrives
    assign last_word_c = (17'(words_loaded) + 17'd1) == 17'(count_q);

    loader_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clr          (sync_c),
        .byte_valid   (data_byte_c),
        .byte_data    (bus.rx_data),
        .word_ready_c (word_ready_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:   if (sync_c) state_n = CNT_HI;
            CNT_HI: if (fire_c) state_n = CNT_LO;
            CNT_LO: begin
                if (fire_c) begin
                    if (cnt_c == 16'd0)               state_n = CHECK;
                    else if (32'(cnt_c) > MAX_WORDS)  state_n = ERR;
                    else                              state_n = DATA;
                end
            end
            DATA:   if (word_ready_c && last_word_c) state_n = CHECK;
            CHECK:  if (fire_c) state_n = (bus.rx_data == csum_q) ? DONE : ERR;
            DONE:   state_n = IDLE;
            ERR:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status outputs follow the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rx_ready   <= 1'b1;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b0;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
            words_loaded   <= '0;
            count_q        <= '0;
            csum_q         <= '0;
        end else begin
            bus.rx_ready <= !((state_n == DONE) || (state_n == ERR));
            cpu_hold     <= (state_n != IDLE);
            load_done    <= (state_n == DONE);
            bus.imem_we  <= word_ready_c;

            if (word_ready_c) begin
                bus.imem_addr  <= BASE_ADDR + ADDR_W'({words_loaded, 2'b00});
                bus.imem_wdata <= word_c;
            end

            if (sync_c) begin
                load_error   <= 1'b0;
                words_loaded <= '0;
                csum_q       <= '0;
            end else begin
                if (state_n == ERR) load_error <= 1'b1;
                if (word_ready_c)   words_loaded <= words_loaded + 16'd1;
                if (data_byte_c)    csum_q <= csum_q ^ bus.rx_data;
            end

            if ((state_q == CNT_HI) && fire_c) count_q[15:8] <= bus.rx_data;
            if ((state_q == CNT_LO) && fire_c) count_q[7:0]  <= bus.rx_data;
        end
    end

endmodule
